// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array sequencer: FSM state encoding,
// default geometry and the skew-drain length helper.
package systolic_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_LOADW  = 3'd2,
    S_STREAM = 3'd3,
    S_DRAIN  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam int unsigned ROWS_DEF     = 4;
  localparam int unsigned COLS_DEF     = 4;
  localparam int unsigned CNT_BITS_DEF = 16;

  // Cycles needed to flush the diagonal skew out of the array.
  function automatic int unsigned DRAIN_CYCLES(input int unsigned rows,
                                               input int unsigned cols);
    return (rows + cols >= 2) ? rows + cols - 2 : 0;
  endfunction

endpackage

// File: rtl/systolic_array_ctrl.sv
// Tile sequencer for a weight-stationary ROWS x COLS systolic array.
// One accepted start runs: CLEAR -> LOADW (ROWS weight beats) -> STREAM
// (k_len activation beats) -> DRAIN (skew flush) -> DONE (done pulse).
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start, abort, k_len tile command from the scheduler
//   busy, done          tile status
//   w_valid / w_ready   weight row handshake (LOADW)
//   a_valid / a_ready   activation handshake (STREAM)
//   feed_zero           edge feeders inject zeros during DRAIN
//   pe_*                broadcast PE controls, aligned with accepted beats
module systolic_array_ctrl
  import systolic_pkg::*;
#(
  parameter int unsigned ROWS     = ROWS_DEF,
  parameter int unsigned COLS     = COLS_DEF,
  parameter int unsigned CNT_BITS = CNT_BITS_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [CNT_BITS-1:0] k_len,
  output logic                busy,
  output logic                done,
  input  logic                w_valid,
  output logic                w_ready,
  input  logic                a_valid,
  output logic                a_ready,
  output logic                feed_zero,
  output logic                pe_enable,
  output logic                pe_clear_acc,
  output logic                pe_load_weight,
  output logic                pe_compute_enable
);

  localparam int unsigned DRAIN = DRAIN_CYCLES(ROWS, COLS);

  localparam logic [CNT_BITS-1:0] ONE       = CNT_BITS'(1);
  localparam logic [CNT_BITS-1:0] ROWS_LAST = CNT_BITS'(ROWS - 1);
  localparam logic [CNT_BITS-1:0] DRN_LAST  = CNT_BITS'(DRAIN - 1);

  state_t              state, state_next;
  logic [CNT_BITS-1:0] count, count_next;
  logic [CNT_BITS-1:0] k_lat, k_lat_next;

  // State, shared beat counter and latched tile length.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      count <= '0;
      k_lat <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      k_lat <= k_lat_next;
    end
  end

  // Next-state, counter and output decode.
  always_comb begin
    state_next        = state;
    count_next        = count;
    k_lat_next        = k_lat;
    busy              = 1'b0;
    done              = 1'b0;
    w_ready           = 1'b0;
    a_ready           = 1'b0;
    feed_zero         = 1'b0;
    pe_enable         = 1'b0;
    pe_clear_acc      = 1'b0;
    pe_load_weight    = 1'b0;
    pe_compute_enable = 1'b0;

    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          k_lat_next = k_len;
          state_next = S_CLEAR;
        end
      end

      S_CLEAR: begin
        busy         = 1'b1;
        pe_enable    = 1'b1;
        pe_clear_acc = 1'b1;
        state_next   = (k_lat == '0) ? S_DONE : S_LOADW;
      end

      S_LOADW: begin
        busy    = 1'b1;
        w_ready = 1'b1;
        if (w_valid) begin
          pe_enable      = 1'b1;
          pe_load_weight = 1'b1;
          if (count == ROWS_LAST) begin
            count_next = '0;
            state_next = S_STREAM;
          end else begin
            count_next = count + ONE;
          end
        end
      end

      S_STREAM: begin
        busy    = 1'b1;
        a_ready = 1'b1;
        if (a_valid) begin
          pe_enable         = 1'b1;
          pe_compute_enable = 1'b1;
          // k_lat is nonzero here: CLEAR bypasses this state when it is 0.
          if (count == k_lat - ONE) begin
            count_next = '0;
            state_next = (DRAIN == 0) ? S_DONE : S_DRAIN;
          end else begin
            count_next = count + ONE;
          end
        end
      end

      S_DRAIN: begin
        busy              = 1'b1;
        feed_zero         = 1'b1;
        pe_enable         = 1'b1;
        pe_compute_enable = 1'b1;
        if (count == DRN_LAST) begin
          count_next = '0;
          state_next = S_DONE;
        end else begin
          count_next = count + ONE;
        end
      end

      S_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
        count_next = '0;
      end
    endcase

    // Abort freezes the array (accumulators keep their values) and returns to IDLE.
    if (abort) begin
      state_next        = S_IDLE;
      count_next        = '0;
      pe_enable         = 1'b0;
      pe_clear_acc      = 1'b0;
      pe_load_weight    = 1'b0;
      pe_compute_enable = 1'b0;
    end
  end

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Scoreboard bench for systolic_array_ctrl: directed tiles plus randomized
// tiles with random valid stalls, checked against a beat-counting model.
module tb_systolic_array_ctrl;

  localparam int ROWS     = 4;
  localparam int COLS     = 4;
  localparam int CNT_BITS = 16;
  localparam int DRAIN    = ROWS + COLS - 2;
  localparam int NV       = 512;

  logic                clk;
  logic                reset;
  logic                start;
  logic                abort;
  logic [CNT_BITS-1:0] k_len;
  logic                busy;
  logic                done;
  logic                w_valid;
  logic                w_ready;
  logic                a_valid;
  logic                a_ready;
  logic                feed_zero;
  logic                pe_enable;
  logic                pe_clear_acc;
  logic                pe_load_weight;
  logic                pe_compute_enable;

  systolic_array_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .CNT_BITS(CNT_BITS)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .k_len(k_len),
    .busy(busy), .done(done), .w_valid(w_valid), .w_ready(w_ready),
    .a_valid(a_valid), .a_ready(a_ready), .feed_zero(feed_zero),
    .pe_enable(pe_enable), .pe_clear_acc(pe_clear_acc),
    .pe_load_weight(pe_load_weight), .pe_compute_enable(pe_compute_enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int done_cyc;
    int loads;
    int comps;
    int ens;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  bit   wv[NV];
  bit   av[NV];

  int   m_loads = 0;
  int   m_comps = 0;
  int   m_ens   = 0;
  exp_t mon_e;

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic int outs_vec();
    return int'({busy, done, w_ready, a_ready, feed_zero, pe_enable,
                 pe_clear_acc, pe_load_weight, pe_compute_enable});
  endfunction

  // Monitor: tallies PE beats per tile and scores each done pulse.
  always @(negedge clk) begin
    if (reset) begin
      m_loads = 0;
      m_comps = 0;
      m_ens   = 0;
    end else begin
      if (pe_clear_acc) begin
        m_loads = 0;
        m_comps = 0;
        m_ens   = 0;
      end
      if (pe_enable)         m_ens++;
      if (pe_load_weight)    m_loads++;
      if (pe_compute_enable) m_comps++;
      if (done) begin
        if (sbq.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          mon_e = sbq.pop_front();
          check("done_cycle", cyc, mon_e.done_cyc);
          check("load_beats", m_loads, mon_e.loads);
          check("compute_beats", m_comps, mon_e.comps);
          check("enable_cycles", m_ens, mon_e.ens);
        end
      end else if (sbq.size() > 0 && cyc > sbq[0].done_cyc + 4) begin
        mon_e = sbq.pop_front();
        check("done_timeout", cyc, mon_e.done_cyc);
      end
    end
  end

  task automatic step(input logic s, input logic ab, input logic wvv,
                      input logic avv, input logic [CNT_BITS-1:0] kk);
    @(posedge clk);
    #1;
    start   = s;
    abort   = ab;
    w_valid = wvv;
    a_valid = avv;
    k_len   = kk;
  endtask

  task automatic fill_valids(input int stall_pct);
    for (int i = 0; i < NV; i++) begin
      wv[i] = (i >= 300) ? 1'b1 : ($urandom_range(0, 99) >= stall_pct);
      av[i] = (i >= 300) ? 1'b1 : ($urandom_range(0, 99) >= stall_pct);
    end
  endtask

  // Reference: walk the valid schedule counting accepted beats.
  function automatic int model_done(input int k);
    int i;
    int n;
    if (k == 0) return 2;
    i = 2;
    n = 0;
    while (n < ROWS) begin
      if (wv[i]) n++;
      i++;
    end
    n = 0;
    while (n < k) begin
      if (av[i]) n++;
      i++;
    end
    return i + DRAIN;
  endfunction

  // Start a tile, push its expectation, drive valids until its DONE cycle.
  task automatic run_tile(input int k, input int off, input bit hold);
    int   t0;
    exp_t e;
    step(1'b1, 1'b0, wv[0], av[0], CNT_BITS'(k));
    t0         = cyc;
    e.done_cyc = t0 + off;
    e.loads    = (k == 0) ? 0 : ROWS;
    e.comps    = (k == 0) ? 0 : k + DRAIN;
    e.ens      = (k == 0) ? 1 : 1 + ROWS + k + DRAIN;
    sbq.push_back(e);
    for (int i = 1; i <= off; i++)
      step(hold, 1'b0, wv[i], av[i], CNT_BITS'($urandom));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int pct;
    reset   = 1'b1;
    start   = 1'b0;
    abort   = 1'b0;
    w_valid = 1'b0;
    a_valid = 1'b0;
    k_len   = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_outputs", outs_vec(), 0);

    // Unstalled 4x4, k=8: done 20 cycles after start.
    fill_valids(0);
    run_tile(8, 20, 1'b0);
    // k=0: clear then done two cycles after start.
    run_tile(0, 2, 1'b0);
    // Three-cycle stalls on the 2nd weight row and 3rd activation beat.
    fill_valids(0);
    for (int i = 3; i <= 5; i++) wv[i] = 1'b0;
    for (int i = 11; i <= 13; i++) av[i] = 1'b0;
    run_tile(8, 26, 1'b0);

    // Abort after three stream beats.
    fill_valids(0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 16'd8);
    for (int i = 1; i <= 8; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 16'd8);
    step(1'b0, 1'b1, 1'b1, 1'b1, 16'd8);
    @(negedge clk);
    check("abort_pe_zero",
          int'({pe_enable, pe_clear_acc, pe_load_weight, pe_compute_enable}), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    @(negedge clk);
    check("abort_busy", int'(busy), 0);
    repeat (25) step(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    run_tile(5, 17, 1'b0);

    // Start held high: back-to-back tiles relaunch only from IDLE.
    run_tile(3, 15, 1'b1);
    run_tile(1, 13, 1'b1);
    run_tile(0, 2, 1'b1);

    // Start together with abort in IDLE.
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'd3);
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    @(negedge clk);
    check("start_abort_idle", int'(busy), 0);
    repeat (5) step(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);

    // Reset while in DRAIN.
    step(1'b1, 1'b0, 1'b1, 1'b1, 16'd2);
    for (int i = 1; i <= 8; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 16'd2);
    reset = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    reset = 1'b0;
    @(negedge clk);
    check("reset_in_drain", outs_vec(), 0);
    repeat (25) step(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);

    // Randomized tiles with random stalls.
    repeat (20) begin
      k   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2))
                                        : int'($urandom_range(3, 20));
      pct = int'($urandom_range(0, 50));
      fill_valids(pct);
      run_tile(k, model_done(k), bit'($urandom_range(0, 1)));
    end

    repeat (10) step(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    check("scoreboard_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
